// File: rtl/rtp_slave.sv
// rtp_slave: byte-wide SPI responder (mode 0, MSB first) for the
// resistive-touch-panel link. SCK/MOSI are oversampled with clk; received
// bytes are assembled into rx_data and a host-supplied reply byte is shifted
// out on miso. A one-deep holding register decouples the host handshake
// from the serial byte slot.
//
// Optional feature: define RTP_SLAVE_TIMEOUT_EN to abandon a byte after
// TIMEOUT clk cycles without an SCK edge (pulses frame_err). Without it a
// stalled byte stays open and frame_err is always 0.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sck, mosi           serial clock / data from master (asynchronous)
//   miso                reply data to master (tx_shift[7])
//   tx_data, tx_valid   reply byte offer;  tx_ready: holding register empty
//   rx_data, rx_valid   last received byte; one-cycle pulse on update
//   busy                byte in progress
//   underrun            pulse: byte started with no reply loaded
//   frame_err           pulse: timeout abandoned a byte
`timescale 1ns/1ps
module rtp_slave #(
  parameter logic [7:0] FILL    = 8'hFF,
  parameter int         TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       underrun,
  output logic       frame_err
);

  logic       sck_m, sck_s, sck_d;
  logic       mosi_m, mosi_s;
  logic       rise, fall;
  logic [3:0] bit_cnt;
  logic       armed;
  logic [7:0] tx_shift, rx_shift;
  logic [7:0] hold_data;
  logic       hold_full;
  logic       slot_open, load, to_fire;

  // two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sck_m  <= sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  assign rise      = sck_s & ~sck_d;
  assign fall      = ~sck_s & sck_d;
  assign slot_open = (bit_cnt == 4'd0) && !armed;
  assign busy      = (bit_cnt != 4'd0);
  assign miso      = tx_shift[7];
  assign tx_ready  = ~hold_full;
  // Loading only on edge-free cycles keeps the edge actions unambiguous;
  // a byte that starts while the holding byte waits is an underrun and the
  // holding byte waits for the next slot.
  assign load      = slot_open && hold_full && !rise && !fall && !to_fire;

`ifdef RTP_SLAVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             to_cnt <= '0;
    else if (rise || fall || !busy || to_fire) to_cnt <= '0;
    else                                    to_cnt <= to_cnt + 1'b1;
  end

  // fires on the TIMEOUT-th consecutive idle cycle of an open byte
  assign to_fire = busy && !rise && !fall && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign to_fire = 1'b0;
`endif

  // holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  // byte engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 4'd0;
      armed     <= 1'b0;
      tx_shift  <= FILL;
      rx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= to_fire;
      if (to_fire) begin
        bit_cnt  <= 4'd0;
        armed    <= 1'b0;
        tx_shift <= FILL;
        rx_shift <= 8'h00;
      end else if (rise) begin
        // saturate at 8: an extra rise before the boundary fall is dropped
        if (bit_cnt != 4'd8) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 4'd1;
        end
        if (slot_open) begin
          underrun <= 1'b1;
          tx_shift <= FILL;
        end
        if (bit_cnt == 4'd7) begin
          rx_data  <= {rx_shift[6:0], mosi_s};
          rx_valid <= 1'b1;
        end
      end else if (fall) begin
        if (bit_cnt == 4'd8) begin
          bit_cnt  <= 4'd0;
          armed    <= 1'b0;
          tx_shift <= FILL;
        end else if (bit_cnt != 4'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end else if (load) begin
        tx_shift <= hold_data;
        armed    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtp_slave.sv
`timescale 1ns/1ps
module tb_rtp_slave;
  localparam logic [7:0] FILL = 8'hFF;

  logic       clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0;
  logic       miso, tx_ready, rx_valid, busy, underrun, frame_err;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       tx_valid = 1'b0;

  rtp_slave #(.FILL(FILL), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .underrun(underrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int und_cnt = 0, und_exp = 0, fe_cnt = 0, fe_exp = 0;
  logic [7:0] reply_q[$];   // reply bytes accepted by the responder, in order
  logic [7:0] exp_rx[$];    // bytes the DUT must report on rx_valid
  logic [7:0] exp_miso[$];  // bytes the master must receive
  bit         mon_en = 1'b0;
  int         mbits = 0;
  logic [7:0] mbyte = 8'h00;
  logic [7:0] rb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [7:0] v);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got byte %0h, want none", nm, v);
  endtask

  // rx / pulse monitor
  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      if (exp_rx.size() == 0) unexpected("rx_unexpected", rx_data);
      else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    if (underrun)  und_cnt++;
    if (frame_err) fe_cnt++;
  end

  // master-side receive monitor: samples miso on each SCK rising edge
  initial forever begin
    @(posedge sck or negedge rst_n);
    if (!rst_n) mbits = 0;
    else if (mon_en) begin
      mbyte = {mbyte[6:0], miso};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (exp_miso.size() == 0) unexpected("miso_unexpected", mbyte);
        else check("miso_byte", 32'(mbyte), 32'(exp_miso.pop_front()));
      end
    end
  end

  // host handshake; caller sits at a negedge
  task automatic offer(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL offer_wait: tx_ready stayed 0 for %0d cycles, want 1", n);
      tx_valid = 1'b0;
    end else begin
      @(negedge clk);
      tx_valid = 1'b0;
      reply_q.push_back(b);
    end
  endtask

  // 32 clk per bit, SCK high for the second 16
  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sck  = 1'b0;
      mosi = b[7-i];
      repeat (15) @(negedge clk);
      sck = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  // model: each byte consumes the oldest accepted reply, else FILL + underrun
  task automatic byte_start(input logic [7:0] b, input bit full);
    logic [7:0] r;
    if (reply_q.size() != 0) r = reply_q.pop_front();
    else begin
      r = FILL;
      und_exp++;
    end
    if (full) begin
      exp_rx.push_back(b);
      exp_miso.push_back(r);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_start(b, 1'b1);
    mon_en = 1'b1;
    bits(b, 8);
    @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    byte_start(b, 1'b0);
    mon_en = 1'b0;
    bits(b, n);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sck = 1'b0;
    mosi = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reply_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso",      32'(miso),      32'(FILL[7]));
    check("rst_tx_ready",  32'(tx_ready),  32'd1);
    check("rst_rx_data",   32'(rx_data),   32'h00);
    check("rst_rx_valid",  32'(rx_valid),  32'd0);
    check("rst_underrun",  32'(underrun),  32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // queued reply
    offer(8'hA5);
    repeat (2) @(negedge clk);
    check("ready_after_load", 32'(tx_ready), 32'd1);
    send_byte(8'h3C);
    repeat (20) @(negedge clk);
    check("t1_underrun", 32'(und_cnt), 32'(und_exp));

    // no reply queued
    send_byte(8'h81);
    repeat (20) @(negedge clk);
    check("t2_underrun", 32'(und_cnt), 32'(und_exp));
    check("t2_rx_data",  32'(rx_data), 32'h81);

    // two replies, second offered while the first still occupies the holding register
    offer(8'h12);
    check("ready_drop", 32'(tx_ready), 32'd0);
    fork
      begin send_byte(8'hC6); send_byte(8'h39); end
      offer(8'h34);
    join
    repeat (20) @(negedge clk);
    check("t3_underrun", 32'(und_cnt), 32'(und_exp));

    // reset mid-byte
    partial(8'hAA, 3);
    @(negedge clk);
    rst_n = 1'b0;
    sck = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_miso",     32'(miso),     32'(FILL[7]));
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_rx_data",  32'(rx_data),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    reply_q.delete();
    repeat (3) @(negedge clk);
    send_byte(8'h55);
    repeat (20) @(negedge clk);
    check("t4_rx_data", 32'(rx_data), 32'h55);

    // randomized traffic
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        rb = 8'($urandom);
        offer(rb);
      end
      repeat (4) @(negedge clk);
      rb = 8'($urandom);
      send_byte(rb);
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("rand_underrun", 32'(und_cnt), 32'(und_exp));

`ifdef RTP_SLAVE_TIMEOUT_EN
    // stalled byte is abandoned; the loaded reply is lost with it
    offer(8'h5A);
    repeat (3) @(negedge clk);
    partial(8'h96, 4);
    @(negedge clk);
    sck = 1'b0;
    fe_exp++;
    repeat (30) @(negedge clk);
    check("to_busy_mid", 32'(busy), 32'd1);
    repeat (70) @(negedge clk);
    check("to_busy_after", 32'(busy),   32'd0);
    check("to_frame_err",  32'(fe_cnt), 32'(fe_exp));
    send_byte(8'hC3);
    repeat (20) @(negedge clk);
    check("to_rx_data", 32'(rx_data), 32'hC3);
`endif

    // single-sample glitch on idle SCK counts as a rise
    @(negedge clk);
    sck = 1'b1;
    @(negedge clk);
    sck = 1'b0;
    und_exp++;
    repeat (6) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd1);
`ifdef RTP_SLAVE_TIMEOUT_EN
    repeat (80) @(negedge clk);
    fe_exp++;
    check("glitch_realign", 32'(busy), 32'd0);
`else
    pulse_reset();
    check("glitch_rst_busy", 32'(busy), 32'd0);
`endif
    send_byte(8'h0F);
    repeat (20) @(negedge clk);
    check("glitch_rx_data", 32'(rx_data), 32'h0F);

    check("end_underrun",  32'(und_cnt),         32'(und_exp));
    check("end_frame_err", 32'(fe_cnt),          32'(fe_exp));
    check("end_rx_left",   32'(exp_rx.size()),   32'd0);
    check("end_miso_left", 32'(exp_miso.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
